// File: rtl/fwd_pkg.sv
// Shared types and constants for the forwarding/hazard unit: select codes,
// pipeline tag records and the common tag-hit test.
package fwd_pkg;

  localparam int unsigned REG_BITS = 5;
  localparam logic [REG_BITS-1:0] ZERO_REG = REG_BITS'(31);

  // Encoding matches the operand 4:1 mux input order.
  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10,
    FWD_IMM   = 2'b11
  } fwd_sel_t;

  typedef struct packed {
    logic [REG_BITS-1:0] rd;
    logic                regwrite;
  } stage_tag_t;

  typedef struct packed {
    logic [REG_BITS-1:0] rn;
    logic [REG_BITS-1:0] rm;
    logic [REG_BITS-1:0] rd;
    logic                use_rn;
    logic                use_rm;
    logic                regwrite;
    logic                memread;
    logic                alusrc;
  } idex_tag_t;

  // A later stage can supply rs only if it really writes it and rs is not XZR.
  function automatic logic tag_hits(stage_tag_t tag, logic [REG_BITS-1:0] rs, logic use_rs);
    return tag.regwrite && use_rs && (tag.rd == rs) && (rs != ZERO_REG);
  endfunction

endpackage

// File: rtl/fwd_select.sv
// Priority select for one ALU operand: immediate override, then EX/MEM,
// then MEM/WB, else the register file.
module fwd_select
  import fwd_pkg::*;
(
  input  logic [REG_BITS-1:0] rs,
  input  logic                use_rs,
  input  logic                imm_sel,
  input  stage_tag_t          exmem,
  input  stage_tag_t          memwb,
  output fwd_sel_t            sel
);

  always_comb begin
    sel = FWD_RF;
    if (imm_sel) begin
      sel = FWD_IMM;
    end else if (tag_hits(exmem, rs, use_rs)) begin
      sel = FWD_EXMEM;
    end else if (tag_hits(memwb, rs, use_rs)) begin
      sel = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Tag pipeline (ID/EX, EX/MEM, MEM/WB) with operand forwarding selects,
// load-use stall detection and the register-file write tag.
module fwd_hazard_unit
  import fwd_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic [REG_BITS-1:0] id_rn,
  input  logic [REG_BITS-1:0] id_rm,
  input  logic                id_use_rn,
  input  logic                id_use_rm,
  input  logic [REG_BITS-1:0] id_rd,
  input  logic                id_regwrite,
  input  logic                id_memread,
  input  logic                id_alusrc,
  input  logic                flush,
  output logic [1:0]          fwd_a,
  output logic [1:0]          fwd_b,
  output logic                load_stall,
  output logic [REG_BITS-1:0] wb_rd,
  output logic                wb_regwrite
);

  idex_tag_t  idex_q, idex_d;
  stage_tag_t exmem_q, memwb_q;
  fwd_sel_t   sel_a, sel_b;

  // The load's data is not ready until MEM/WB, so a dependent ID instruction waits one cycle.
  assign load_stall = idex_q.memread && idex_q.regwrite && (idex_q.rd != ZERO_REG) &&
                      ((id_use_rn && (id_rn == idex_q.rd)) ||
                       (id_use_rm && (id_rm == idex_q.rd)));

  always_comb begin
    idex_d = '0;
    if (!(flush || load_stall)) begin
      idex_d.rn       = id_rn;
      idex_d.rm       = id_rm;
      idex_d.rd       = id_rd;
      idex_d.use_rn   = id_use_rn;
      idex_d.use_rm   = id_use_rm;
      idex_d.regwrite = id_regwrite;
      idex_d.memread  = id_memread;
      idex_d.alusrc   = id_alusrc;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      idex_q  <= '0;
      exmem_q <= '0;
      memwb_q <= '0;
    end else begin
      idex_q           <= idex_d;
      exmem_q.rd       <= idex_q.rd;
      exmem_q.regwrite <= idex_q.regwrite;
      memwb_q          <= exmem_q;
    end
  end

  fwd_select u_sel_a (
    .rs      (idex_q.rn),
    .use_rs  (idex_q.use_rn),
    .imm_sel (1'b0),
    .exmem   (exmem_q),
    .memwb   (memwb_q),
    .sel     (sel_a)
  );

  fwd_select u_sel_b (
    .rs      (idex_q.rm),
    .use_rs  (idex_q.use_rm),
    .imm_sel (idex_q.alusrc),
    .exmem   (exmem_q),
    .memwb   (memwb_q),
    .sel     (sel_b)
  );

  assign fwd_a       = sel_a;
  assign fwd_b       = sel_b;
  assign wb_rd       = memwb_q.rd;
  assign wb_regwrite = memwb_q.regwrite;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed vector table plus randomized traffic checked against an in-flight
// instruction model of the forwarding/hazard rules.
module tb_fwd_hazard_unit;

  typedef struct packed {
    logic [4:0] rn;
    logic       urn;
    logic [4:0] rm;
    logic       urm;
    logic [4:0] rd;
    logic       rw;
    logic       mr;
    logic       als;
    logic       fl;
  } id_t;

  typedef struct packed {
    logic       rst_n;
    id_t        id;
    logic [1:0] fa;
    logic [1:0] fb;
    logic       ls;
    logic [4:0] wrd;
    logic       wrw;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  id_t        cur;
  logic [1:0] fwd_a, fwd_b;
  logic       load_stall;
  logic [4:0] wb_rd;
  logic       wb_regwrite;

  int checks = 0;
  int errors = 0;

  vec_t vecs[$];
  // Model: instructions in flight, index 0 = EX, 1 = MEM, 2 = WB.
  id_t  pipe[3];

  always #5 clk = ~clk;

  fwd_hazard_unit dut (
    .clk         (clk),
    .reset       (reset),
    .id_rn       (cur.rn),
    .id_rm       (cur.rm),
    .id_use_rn   (cur.urn),
    .id_use_rm   (cur.urm),
    .id_rd       (cur.rd),
    .id_regwrite (cur.rw),
    .id_memread  (cur.mr),
    .id_alusrc   (cur.als),
    .flush       (cur.fl),
    .fwd_a       (fwd_a),
    .fwd_b       (fwd_b),
    .load_stall  (load_stall),
    .wb_rd       (wb_rd),
    .wb_regwrite (wb_regwrite)
  );

  function automatic id_t ins(int rn, int urn, int rm, int urm, int rd, int rw, int mr,
                              int als, int fl);
    id_t r;
    r.rn = 5'(rn); r.urn = 1'(urn); r.rm = 5'(rm); r.urm = 1'(urm); r.rd = 5'(rd);
    r.rw = 1'(rw); r.mr = 1'(mr); r.als = 1'(als); r.fl = 1'(fl);
    return r;
  endfunction

  task automatic add(int rst_n, id_t id, int fa, int fb, int ls, int wrd, int wrw);
    vec_t v;
    v.rst_n = 1'(rst_n); v.id = id; v.fa = 2'(fa); v.fb = 2'(fb); v.ls = 1'(ls);
    v.wrd = 5'(wrd); v.wrw = 1'(wrw);
    vecs.push_back(v);
  endtask

  task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  // The source comes from the youngest older instruction that writes it.
  function automatic logic [1:0] m_sel(logic [4:0] r, logic u);
    for (int k = 1; k <= 2; k++)
      if (u && r != 5'd31 && pipe[k].rw && pipe[k].rd == r) return 2'(k);
    return 2'd0;
  endfunction

  function automatic logic m_stall(id_t id);
    id_t ld = pipe[0];
    return ld.mr && ld.rw && ld.rd != 5'd31 &&
           ((id.urn && id.rn == ld.rd) || (id.urm && id.rm == ld.rd));
  endfunction

  task automatic model_check(string tag, int idx);
    logic [1:0] eb;
    eb = pipe[0].als ? 2'd3 : m_sel(pipe[0].rm, pipe[0].urm);
    chk({tag, ".fwd_a"}, idx, 32'(fwd_a), 32'(m_sel(pipe[0].rn, pipe[0].urn)));
    chk({tag, ".fwd_b"}, idx, 32'(fwd_b), 32'(eb));
    chk({tag, ".load_stall"}, idx, 32'(load_stall), 32'(m_stall(cur)));
    chk({tag, ".wb_rd"}, idx, 32'(wb_rd), 32'(pipe[2].rd));
    chk({tag, ".wb_regwrite"}, idx, 32'(wb_regwrite), 32'(pipe[2].rw));
  endtask

  task automatic model_step(logic rst_n, id_t id, logic stall);
    if (!rst_n) begin
      pipe[0] = '0; pipe[1] = '0; pipe[2] = '0;
    end else begin
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = (id.fl || stall) ? id_t'('0) : id;
    end
  endtask

  task automatic cycle(logic rst_n, id_t id, string tag, int idx, logic use_tbl, vec_t v);
    logic s;
    reset = rst_n;
    cur   = id;
    @(negedge clk);
    if (use_tbl) begin
      chk("tbl.fwd_a", idx, 32'(fwd_a), 32'(v.fa));
      chk("tbl.fwd_b", idx, 32'(fwd_b), 32'(v.fb));
      chk("tbl.load_stall", idx, 32'(load_stall), 32'(v.ls));
      chk("tbl.wb_rd", idx, 32'(wb_rd), 32'(v.wrd));
      chk("tbl.wb_regwrite", idx, 32'(wb_regwrite), 32'(v.wrw));
    end
    model_check(tag, idx);
    s = m_stall(id);
    @(posedge clk);
    model_step(rst_n, id, s);
    #1;
  endtask

  function automatic logic [4:0] rnd_reg();
    int r = $urandom_range(0, 4);
    return (r == 4) ? 5'd31 : 5'(r);
  endfunction

  initial begin
    id_t NOP;
    vec_t dummy;
    NOP = '0;
    dummy = '0;

    // 1: EX/MEM forward to A
    add(1, NOP, 0, 0, 0, 0, 0);
    add(1, ins(4, 1, 5, 1, 1, 1, 0, 0, 0), 0, 0, 0, 0, 0);
    add(1, ins(1, 1, 6, 1, 7, 1, 0, 0, 0), 0, 0, 0, 0, 0);
    add(1, NOP, 1, 0, 0, 0, 0);
    add(1, NOP, 0, 0, 0, 1, 1);
    // 2: MEM/WB forward to B (A picks up the unrelated MOV from EX/MEM)
    add(1, ins(0, 0, 0, 0, 1, 1, 0, 0, 0), 0, 0, 0, 7, 1);
    add(1, ins(0, 0, 0, 0, 9, 1, 0, 0, 0), 0, 0, 0, 0, 0);
    add(1, ins(9, 1, 1, 1, 10, 1, 0, 0, 0), 0, 0, 0, 0, 0);
    add(1, NOP, 1, 2, 0, 1, 1);
    // 3: EX/MEM wins over MEM/WB
    add(1, ins(0, 0, 0, 0, 2, 1, 0, 0, 0), 0, 0, 0, 9, 1);
    add(1, ins(0, 0, 0, 0, 2, 1, 0, 0, 0), 0, 0, 0, 10, 1);
    add(1, ins(2, 1, 0, 0, 11, 1, 0, 0, 0), 0, 0, 0, 0, 0);
    add(1, NOP, 1, 0, 0, 2, 1);
    // 4: load-use stall, bubble, then MEM/WB forward
    add(1, ins(0, 0, 0, 0, 3, 1, 1, 0, 0), 0, 0, 0, 2, 1);
    add(1, ins(3, 1, 0, 0, 12, 1, 0, 0, 0), 0, 0, 1, 11, 1);
    add(1, ins(3, 1, 0, 0, 12, 1, 0, 0, 0), 0, 0, 0, 0, 0);
    add(1, NOP, 2, 0, 0, 3, 1);
    // 5: zero register never forwards or stalls
    add(1, ins(0, 0, 0, 0, 31, 1, 0, 0, 0), 0, 0, 0, 0, 0);
    add(1, ins(31, 1, 0, 0, 13, 1, 0, 0, 0), 0, 0, 0, 12, 1);
    add(1, ins(0, 0, 0, 0, 31, 1, 1, 0, 0), 0, 0, 0, 0, 0);
    add(1, ins(31, 1, 31, 1, 14, 1, 0, 0, 0), 0, 0, 0, 31, 1);
    // 6: immediate override, then mid-stream reset
    add(1, ins(0, 0, 14, 1, 15, 1, 0, 1, 0), 0, 0, 0, 13, 1);
    add(1, NOP, 0, 3, 0, 31, 1);
    add(0, NOP, 0, 0, 0, 14, 1);
    add(1, NOP, 0, 0, 0, 0, 0);
    // Flush squashes the producer; flush with stall gives one bubble
    add(1, ins(0, 0, 0, 0, 5, 1, 0, 0, 1), 0, 0, 0, 0, 0);
    add(1, ins(5, 1, 0, 0, 0, 0, 0, 0, 0), 0, 0, 0, 0, 0);
    add(1, NOP, 0, 0, 0, 0, 0);
    add(1, ins(0, 0, 0, 0, 6, 1, 1, 0, 0), 0, 0, 0, 0, 0);
    add(1, ins(6, 1, 0, 0, 0, 0, 0, 0, 1), 0, 0, 1, 0, 0);
    add(1, NOP, 0, 0, 0, 0, 0);
    add(1, NOP, 0, 0, 0, 6, 1);

    reset = 1'b0;
    cur   = NOP;
    repeat (2) @(posedge clk);
    model_step(1'b0, NOP, 1'b0);
    #1;

    foreach (vecs[i]) cycle(vecs[i].rst_n, vecs[i].id, "dir", i, 1'b1, vecs[i]);

    for (int n = 0; n < 3000; n++) begin
      id_t r;
      logic rst_n;
      r.rn  = rnd_reg();
      r.rm  = rnd_reg();
      r.rd  = rnd_reg();
      r.urn = 1'($urandom);
      r.urm = 1'($urandom);
      r.rw  = ($urandom_range(0, 3) != 0);
      r.mr  = ($urandom_range(0, 2) == 0);
      r.als = ($urandom_range(0, 3) == 0);
      r.fl  = ($urandom_range(0, 7) == 0);
      rst_n = ($urandom_range(0, 59) != 0);
      cycle(rst_n, r, "rnd", n, 1'b0, dummy);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
